fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front-end for the single-cycle MIPS datapath. It owns the program counter and drives the word address into the combinational instruction ROM. It captures the returned 32-bit word together with its address into a 2-entry buffer and presents it to the decode stage over a valid/ready handshake. Branch/jump redirects flush the buffer. An all-zero fetched word stops fetching, because the ROM returns 0 past the end of the program.

## Interface
Parameters:
- `ADDR_W`, 8: instruction word-address width; PC wraps modulo 2^ADDR_W.
- `DATA_W`, 32: instruction width.
- `STOP_ON_ZERO`, 1: when 1, a fetched word equal to 0 halts fetch and is not delivered.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  reset.
- `en`  in  1  fetch enable; 0 freezes PC and fetch. Buffer still drains.
- `imem_addr`  out  ADDR_W  word address to the ROM; always equals the PC register.
- `imem_rd`  in  DATA_W  ROM read data, combinational from `imem_addr`.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_addr`  in  ADDR_W  new PC value.
- `inst_valid`  out  1  buffer head is valid.
- `inst_data`  out  DATA_W  buffer head instruction.
- `inst_pc`  out  ADDR_W  buffer head address.
- `inst_ready`  in  1  decode accepts the head.
- `halted`  out  1  fetch FSM is in HALT.

## Operation
- FSM has two states, RUN and HALT; reset enters RUN.
- Reset values:
  - PC = 0 and buffer empty.
  - `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `halted`=0.
- Pop: occurs when `inst_valid && inst_ready`.
- Fetch: occurs when state=RUN, `en`=1, `redirect_valid`=0, and either the buffer count is below 2 or a pop occurs this cycle.
- On fetch:
  - If `STOP_ON_ZERO` and `imem_rd`==0: nothing is pushed, PC holds, state goes to HALT.
  - Otherwise {PC, `imem_rd`} is pushed at the buffer tail and PC becomes PC+1, with 0xFF+1 = 0x00.
- Redirect has highest priority, in every state:
  - Buffer is flushed, including any entry that would pop this cycle.
  - PC becomes `redirect_addr` and state becomes RUN.
  - No fetch happens in the redirect cycle.
- Push and pop in the same cycle keep the count unchanged. A full buffer plus a pop allows a fetch.
- Buffer order is strict FIFO. Head outputs are held stable while `inst_valid`=1 and `inst_ready`=0.
- Head outputs read 0 when the buffer is empty.
- HALT holds PC, continues draining the buffer, and is left only by redirect or reset.

## Timing
- ROM access is zero-wait: the data for `imem_addr` is sampled on the same edge.
- Fetch-to-valid latency is 1 cycle. The first instruction after reset release (with `en`=1) is valid on the second cycle.
- Sustained throughput is 1 instruction/cycle with `inst_ready`=1.
- After a redirect:
  - `inst_valid`=0 on the next cycle.
  - `imem_addr`=`redirect_addr` on the next cycle.
  - The first new instruction is valid one cycle later.
- `rst` has priority over everything; asserting it mid-operation discards the buffer and all state.
- All outputs are registered or decoded directly from registers; there is no input-to-output combinational path except through `imem_rd` into the registers.

## Structure
- A shared package `fetch_pkg` holds:
  - The state enum (RUN, HALT).
  - The entry struct {pc, inst}.
  - The `NOP_WORD`=0 constant.
- Natural sub-module: `fetch_buf`, a 2-entry synchronous FIFO with flush, push, pop, count, and head outputs.
- The top level holds the PC, the FSM, and the fetch/redirect priority logic.

## Test plan
All scenarios use a behavioural ROM: word0=0x20010003, word1=0x20020009, word2=0x00221020, remaining words 0 unless stated.
- Reset then `en`=1, `inst_ready`=1:
  - Deliveries are (pc0, 0x20010003), (pc1, 0x20020009), (pc2, 0x00221020) on consecutive cycles starting cycle 2.
  - Then `halted`=1, `imem_addr`=3, and `inst_valid`=0 thereafter.
- Backpressure with `inst_ready`=0 from reset:
  - Count reaches 2 and `imem_addr` stalls at 2 while head stays (pc0, 0x20010003).
  - Raising ready yields pc0, pc1, pc2 in order with no loss or duplication.
- Redirect to 0x05 with the buffer full (word5=0x20030007):
  - Next cycle `inst_valid`=0 and `imem_addr`=5.
  - The following cycle head is (pc5, 0x20030007).
- Redirect while halted to 0x00: `halted` drops next cycle and pc0 is re-delivered.
- Wrap: word255=0x20040001 and word0 as above; redirect to 0xFF gives pc 0xFF then pc 0x00 consecutively.
- Reset mid-stream with the buffer full: next cycle `inst_valid`=0, `imem_addr`=0, `halted`=0, and pc0 is re-delivered.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

   // Entry widths; fetch_unit parameters must agree with these.
   localparam int PC_W   = 8;
   localparam int INST_W = 32;

   localparam logic [INST_W-1:0] NOP_WORD = '0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO holding fetched {pc, inst} pairs.
// Flush wins over push and pop; head reads zero when empty.
module fetch_buf
   import fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  entry_t     push_entry,
   input  logic       pop,
   output entry_t     head,
   output logic       head_valid,
   output logic [1:0] count
);

   entry_t mem [2];
   logic   wr_ptr;
   logic   rd_ptr;
   logic   do_push;
   logic   do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count < 2'd2) || do_pop);

   assign head_valid = (count != 2'd0);
   assign head       = head_valid ? mem[rd_ptr] : '0;

   // Pointer and occupancy update; flush discards everything including a same-cycle pop.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are masked by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front-end: owns the PC, drives the ROM address, buffers fetched
// words and stops on an all-zero word. Redirect beats everything but reset.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter bit STOP_ON_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rd,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic              halted
);

   if (ADDR_W != PC_W || DATA_W != INST_W) begin : g_width_check
      $error("fetch_unit: ADDR_W/DATA_W must match fetch_pkg entry widths");
   end

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        count;
   logic              head_valid;
   entry_t            head;
   entry_t            push_entry;
   logic              pop;
   logic              can_fetch;
   logic              is_zero;
   logic              push;

   assign pop       = head_valid && inst_ready;
   assign can_fetch = (state == ST_RUN) && en && !redirect_valid &&
                      ((count < 2'd2) || pop);
   assign is_zero   = STOP_ON_ZERO && (imem_rd == NOP_WORD);
   assign push      = can_fetch && !is_zero;

   assign push_entry.pc   = pc;
   assign push_entry.inst = imem_rd;

   assign imem_addr  = pc;
   assign inst_valid = head_valid;
   assign inst_data  = head.inst;
   assign inst_pc    = head.pc;
   assign halted     = (state == ST_HALT);

   // PC and RUN/HALT control: redirect first, then fetch advance or halt on zero word.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= '0;
         state <= ST_RUN;
      end else if (redirect_valid) begin
         pc    <= redirect_addr;
         state <= ST_RUN;
      end else if (can_fetch) begin
         if (is_zero) state <= ST_HALT;
         else         pc    <= pc + ADDR_W'(1);
      end
   end

   fetch_buf u_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .head_valid (head_valid),
      .count      (count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios followed
// by randomized enable/ready/redirect/reset traffic against a queue model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rd;
   logic        redirect_valid;
   logic [7:0]  redirect_addr;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [7:0]  inst_pc;
   logic        inst_ready;
   logic        halted;

   logic [31:0] rom [256];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  pc;
      logic [31:0] inst;
   } ment_t;

   ment_t      q[$];
   logic [7:0] m_pc;
   bit         m_halt;

   always #5 clk = ~clk;

   assign imem_rd = rom[imem_addr];

   fetch_unit #(.ADDR_W(8), .DATA_W(32), .STOP_ON_ZERO(1'b1)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .imem_addr      (imem_addr),
      .imem_rd        (imem_rd),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .halted         (halted)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: what the spec says one clock edge does, using the current inputs.
   task automatic model_edge();
      logic [31:0] w;
      if (rst) begin
         q.delete(); m_pc = 8'h00; m_halt = 1'b0;
         return;
      end
      if (redirect_valid) begin
         q.delete(); m_pc = redirect_addr; m_halt = 1'b0;
         return;
      end
      if (q.size() > 0 && inst_ready) void'(q.pop_front());
      if (!m_halt && en && q.size() < 2) begin
         w = rom[m_pc];
         if (w == 32'h0) m_halt = 1'b1;
         else begin
            q.push_back('{pc: m_pc, inst: w});
            m_pc = m_pc + 8'd1;
         end
      end
   endtask

   task automatic compare_all();
      chk("inst_valid", 64'(inst_valid), 64'(q.size() > 0));
      chk("inst_pc",    64'(inst_pc),    (q.size() > 0) ? 64'(q[0].pc)   : 64'h0);
      chk("inst_data",  64'(inst_data),  (q.size() > 0) ? 64'(q[0].inst) : 64'h0);
      chk("imem_addr",  64'(imem_addr),  64'(m_pc));
      chk("halted",     64'(halted),     64'(m_halt));
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk); #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc(); rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'h0;
      rom[0]   = 32'h20010003;
      rom[1]   = 32'h20020009;
      rom[2]   = 32'h00221020;
      rom[5]   = 32'h20030007;
      rom[255] = 32'h20040001;
      rst = 1'b1; en = 1'b1; inst_ready = 1'b1;
      redirect_valid = 1'b0; redirect_addr = 8'h00;

      // Reset state and straight-line delivery until halt
      cyc();
      chk("rst_valid", 64'(inst_valid), 64'h0);
      chk("rst_data",  64'(inst_data),  64'h0);
      chk("rst_pc",    64'(inst_pc),    64'h0);
      chk("rst_addr",  64'(imem_addr),  64'h0);
      chk("rst_halt",  64'(halted),     64'h0);
      rst = 1'b0;
      cyc(); chk("run_d0", {24'h0, inst_pc, inst_data}, {32'h0, 32'h20010003});
      cyc(); chk("run_d1", {24'h0, inst_pc, inst_data}, {24'h0, 8'h01, 32'h20020009});
      cyc(); chk("run_d2", {24'h0, inst_pc, inst_data}, {24'h0, 8'h02, 32'h00221020});
      cyc(); chk("run_halt", {inst_valid, halted, imem_addr}, {1'b0, 1'b1, 8'h03});
      cyc(); chk("run_stay", {inst_valid, halted}, 2'b01);

      // Backpressure: buffer fills, PC stalls at 2, head stable
      inst_ready = 1'b0; do_reset();
      repeat (4) cyc();
      chk("bp_addr", 64'(imem_addr), 64'h2);
      chk("bp_head", {24'h0, inst_pc, inst_data}, {32'h0, 32'h20010003});
      inst_ready = 1'b1;
      cyc(); chk("bp_d1", 64'(inst_pc), 64'h1);
      cyc(); chk("bp_d2", 64'(inst_pc), 64'h2);
      cyc(); chk("bp_end", {inst_valid, halted}, 2'b01);

      // Redirect to 5 with a full buffer
      inst_ready = 1'b0; do_reset();
      repeat (3) cyc();
      redirect_valid = 1'b1; redirect_addr = 8'h05;
      cyc(); chk("rd5_flush", {inst_valid, imem_addr}, {1'b0, 8'h05});
      redirect_valid = 1'b0;
      cyc(); chk("rd5_head", {24'h0, inst_pc, inst_data}, {24'h0, 8'h05, 32'h20030007});
      inst_ready = 1'b1;
      repeat (2) cyc();
      chk("rd5_halt", 64'(halted), 64'h1);

      // Redirect while halted back to 0
      redirect_valid = 1'b1; redirect_addr = 8'h00;
      cyc(); chk("rdh_run", 64'(halted), 64'h0);
      redirect_valid = 1'b0;
      cyc(); chk("rdh_pc0", {inst_valid, inst_pc}, {1'b1, 8'h00});

      // Wrap from 0xFF to 0x00
      redirect_valid = 1'b1; redirect_addr = 8'hFF;
      cyc(); redirect_valid = 1'b0;
      cyc(); chk("wrap_ff", {24'h0, inst_pc, inst_data}, {24'h0, 8'hFF, 32'h20040001});
      cyc(); chk("wrap_00", {inst_valid, inst_pc}, {1'b1, 8'h00});

      // Reset mid-stream with a full buffer
      inst_ready = 1'b0;
      repeat (3) cyc();
      rst = 1'b1;
      cyc(); chk("mrst", {inst_valid, halted, imem_addr}, {1'b0, 1'b0, 8'h00});
      rst = 1'b0;
      cyc(); chk("mrst_pc0", {inst_valid, inst_pc}, {1'b1, 8'h00});

      // Randomized traffic over a denser ROM
      for (int i = 6; i <= 20; i++)    rom[i] = $urandom() | 32'h1;
      for (int i = 250; i <= 254; i++) rom[i] = $urandom() | 32'h1;
      for (int n = 0; n < 3000; n++) begin
         en             = ($urandom_range(0, 9) < 8);
         inst_ready     = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 99) < 5);
         redirect_addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20))
                                                      : 8'($urandom_range(240, 255));
         rst            = ($urandom_range(0, 199) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
